// File: rtl/uart_cmd_sched_if.sv
// rtl/uart_cmd_sched_if.sv - wrapper and client handshake bundle around the command scheduler
interface uart_cmd_sched_if #(
    parameter int NREQ = 4
);
    logic              cmd_rdy;
    logic [15:0]       cmd;
    logic              clr_cmd_rdy;
    logic              send_resp;
    logic [7:0]        resp;
    logic              resp_sent;
    logic [NREQ-1:0]   cmd_vld;
    logic [15:0]       cmd_data;
    logic [NREQ-1:0]   cmd_ack;
    logic [NREQ-1:0]   resp_req;
    logic [8*NREQ-1:0] resp_data;
    logic [NREQ-1:0]   resp_ack;
    logic              busy;

    // master is the scheduler; slave is the wrapper plus clients around it
    modport master (
        input  cmd_rdy, cmd, resp_sent, cmd_ack, resp_req, resp_data,
        output clr_cmd_rdy, send_resp, resp, cmd_vld, cmd_data, resp_ack, busy
    );

    modport slave (
        output cmd_rdy, cmd, resp_sent, cmd_ack, resp_req, resp_data,
        input  clr_cmd_rdy, send_resp, resp, cmd_vld, cmd_data, resp_ack, busy
    );
endinterface

// File: rtl/uart_cmd_sched.sv
// rtl/uart_cmd_sched.sv - command dispatcher and round-robin response arbiter for the UART wrapper
module uart_cmd_sched #(
    parameter int         NREQ     = 4,
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] ERR_RESP = 8'hEE
) (
    input logic              clk,
    input logic              rst,
    uart_cmd_sched_if.master bus
);
    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic       {C_IDLE, C_DISP} cstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT} rstate_t;

    cstate_t cstate, cnext;
    rstate_t rstate, rnext;

    logic [1:0]      dest;
    logic [NREQ-1:0] dest_oh;
    logic [CW-1:0]   tcnt, tcnt_d;
    logic            vld_on, dest_ack, tmo_last;
    logic            clr_d;
    logic [NREQ-1:0] vld_d;
    logic            err_pend, err_set, err_clr;

    logic [NREQ-1:0] req_eff;
    logic            found;
    logic [1:0]      pick, rr_ptr, gnt;
    logic            gnt_err;
    logic            send_d;
    logic [NREQ-1:0] ack_d;

    // ---------------- command side ----------------
    assign vld_on   = |bus.cmd_vld;
    assign dest_ack = bus.cmd_ack[dest];
    assign tmo_last = (tcnt == TO_LAST);

    always_comb begin
        dest_oh       = '0;
        dest_oh[dest] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cstate <= C_IDLE;
        else     cstate <= cnext;
    end

    // C_DISP spends its first cycle raising cmd_vld, so ack/timeout only count once it is up
    always_comb begin
        cnext = cstate;
        case (cstate)
            C_IDLE:  if (bus.cmd_rdy) cnext = C_DISP;
            C_DISP:  if (vld_on && (dest_ack || tmo_last)) cnext = C_IDLE;
            default: cnext = C_IDLE;
        endcase
    end

    always_comb begin
        clr_d   = 1'b0;
        vld_d   = bus.cmd_vld;
        tcnt_d  = '0;
        err_set = 1'b0;
        case (cstate)
            C_IDLE: clr_d = bus.cmd_rdy;
            C_DISP: begin
                if (!vld_on) begin
                    vld_d = dest_oh;
                end else if (dest_ack) begin
                    vld_d = '0;
                end else if (tmo_last) begin
                    vld_d   = '0;
                    err_set = 1'b1;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.clr_cmd_rdy <= 1'b0;
            bus.cmd_vld     <= '0;
            bus.cmd_data    <= '0;
            dest            <= '0;
            tcnt            <= '0;
        end else begin
            bus.clr_cmd_rdy <= clr_d;
            bus.cmd_vld     <= vld_d;
            tcnt            <= tcnt_d;
            if (clr_d) begin
                bus.cmd_data <= bus.cmd;
                dest         <= bus.cmd[15:14];
            end
        end
    end

    // ---------------- response side ----------------
    // resp_ack is registered, so the acked client still shows its request that cycle; mask it
    assign req_eff = bus.resp_req & ~bus.resp_ack;

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_eff[2'(int'(rr_ptr) + k)]) begin
                found = 1'b1;
                pick  = 2'(int'(rr_ptr) + k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rstate <= R_IDLE;
        else     rstate <= rnext;
    end

    always_comb begin
        rnext = rstate;
        case (rstate)
            R_IDLE:  if (found || err_pend) rnext = R_SEND;
            R_SEND:  rnext = R_WAIT;
            R_WAIT:  if (bus.resp_sent) rnext = R_IDLE;
            default: rnext = R_IDLE;
        endcase
    end

    always_comb begin
        send_d  = 1'b0;
        ack_d   = '0;
        err_clr = 1'b0;
        case (rstate)
            R_IDLE: send_d = found | err_pend;
            R_WAIT: begin
                if (bus.resp_sent) begin
                    if (gnt_err) err_clr    = 1'b1;
                    else         ack_d[gnt] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.send_resp <= 1'b0;
            bus.resp_ack  <= '0;
            bus.resp      <= '0;
            gnt           <= '0;
            gnt_err       <= 1'b0;
            rr_ptr        <= '0;
            err_pend      <= 1'b0;
        end else begin
            bus.send_resp <= send_d;
            bus.resp_ack  <= ack_d;
            if (send_d) begin
                gnt     <= pick;
                gnt_err <= ~found;
                if (found) begin
                    bus.resp <= bus.resp_data[{pick, 3'b000} +: 8];
                    rr_ptr   <= pick + 2'd1;
                end else begin
                    bus.resp <= ERR_RESP;
                end
            end
            // a fresh timeout must never be lost to a concurrent clear
            if (err_set)      err_pend <= 1'b1;
            else if (err_clr) err_pend <= 1'b0;
        end
    end

    assign bus.busy = (cstate != C_IDLE) | (rstate != R_IDLE) | err_pend;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb/tb_uart_cmd_sched.sv - self-checking bench for uart_cmd_sched
`timescale 1ns/1ps
module tb_uart_cmd_sched;
    localparam logic [7:0] EE = 8'hEE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_sched_if #(.NREQ(4)) bus ();

    uart_cmd_sched #(.NREQ(4), .TIMEOUT(1024), .ERR_RESP(8'hEE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] cmd;
        int          ack_dly;
        logic [3:0]  exp_vld;
        int          exp_len;
        int          exp_ee;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          ack_dly[4];
    int          vcnt[4];
    int          timer;
    bit          hold_sent;
    int          resp_dly = 20;
    logic [7:0]  sent_q[$];
    int          ack_q[$];
    logic [19:0] disp_q[$];
    int          clr_cyc, rise_cyc, vld_len, first_fall;
    logic [3:0]  prev_vld;
    int          multi_ack;

    vec_t        vecs[5];
    int          start;
    logic [7:0]  exp_b[$];
    int          exp_a[$];
    int          rr_m, idx, last, ad;
    logic [15:0] c;
    logic [3:0]  m, oh;
    logic [31:0] rdata;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        sent_q.delete();
        ack_q.delete();
        disp_q.delete();
        clr_cyc    = -1;
        rise_cyc   = -1;
        vld_len    = -1;
        first_fall = -1;
    endtask

    // one clock: sample just after the edge, then let wrapper and client models react
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.clr_cmd_rdy) begin
            bus.cmd_rdy = 1'b0;
            clr_cyc     = cyc;
        end
        bus.resp_sent = 1'b0;
        if (timer > 0 && !hold_sent) begin
            timer--;
            if (timer == 0) bus.resp_sent = 1'b1;
        end
        if (bus.send_resp) begin
            sent_q.push_back(bus.resp);
            timer = resp_dly;
        end
        if ($countones(bus.resp_ack) > 1) multi_ack++;
        for (int i = 0; i < 4; i++) begin
            if (bus.resp_ack[i]) begin
                ack_q.push_back(i);
                bus.resp_req[i] = 1'b0;
            end
        end
        bus.cmd_ack = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cmd_vld[i]) vcnt[i]++;
            else                vcnt[i] = 0;
            if (bus.cmd_vld[i] && ack_dly[i] >= 0 && vcnt[i] == ack_dly[i] + 1) bus.cmd_ack[i] = 1'b1;
        end
        if (prev_vld == 4'd0 && bus.cmd_vld != 4'd0) begin
            disp_q.push_back({bus.cmd_vld, bus.cmd_data});
            rise_cyc = cyc;
        end
        if (prev_vld != 4'd0 && bus.cmd_vld == 4'd0) begin
            vld_len = cyc - rise_cyc;
            if (first_fall < 0) first_fall = cyc;
        end
        prev_vld = bus.cmd_vld;
    endtask

    task automatic wait_idle(string name, int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while (n < bound && !(n >= 3 && !bus.busy && !bus.cmd_rdy && bus.resp_req == 4'd0
                                  && timer == 0 && !bus.resp_sent));
        check({name, " idle reached"}, n < bound, 1);
    endtask

    task automatic wait_fall(string name, int bound);
        int n = 0;
        while (vld_len < 0 && n < bound) begin
            tick();
            n++;
        end
        check({name, " vld dropped"}, n < bound, 1);
    endtask

    task automatic check_bytes(string name, input logic [7:0] exp[$]);
        check({name, " byte count"}, sent_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sent_q.size(); i++)
            check($sformatf("%s byte%0d", name, i), sent_q[i], exp[i]);
    endtask

    task automatic check_acks(string name, input int exp[$]);
        check({name, " ack count"}, ack_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < ack_q.size(); i++)
            check($sformatf("%s ack%0d", name, i), ack_q[i], exp[i]);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_rdy   = 1'b0;
        bus.cmd       = '0;
        bus.resp_sent = 1'b0;
        bus.cmd_ack   = '0;
        bus.resp_req  = '0;
        bus.resp_data = '0;
        hold_sent     = 1'b0;
        timer         = 0;
        prev_vld      = '0;
        multi_ack     = 0;
        for (int i = 0; i < 4; i++) begin
            ack_dly[i] = 0;
            vcnt[i]    = 0;
        end
        clear_logs();

        vecs[0] = '{cmd: 16'h8A5C, ack_dly: 0,    exp_vld: 4'b0100, exp_len: 1,    exp_ee: 0};
        vecs[1] = '{cmd: 16'h4000, ack_dly: -1,   exp_vld: 4'b0010, exp_len: 1024, exp_ee: 1};
        vecs[2] = '{cmd: 16'h0123, ack_dly: 3,    exp_vld: 4'b0001, exp_len: 4,    exp_ee: 0};
        vecs[3] = '{cmd: 16'hC0FF, ack_dly: 1023, exp_vld: 4'b1000, exp_len: 1024, exp_ee: 0};
        vecs[4] = '{cmd: 16'h7FFF, ack_dly: 7,    exp_vld: 4'b0010, exp_len: 8,    exp_ee: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset clr_cmd_rdy", bus.clr_cmd_rdy, 0);
        check("reset send_resp", bus.send_resp, 0);
        check("reset resp", bus.resp, 0);
        check("reset cmd_vld", bus.cmd_vld, 0);
        check("reset cmd_data", bus.cmd_data, 0);
        check("reset resp_ack", bus.resp_ack, 0);
        check("reset busy", bus.busy, 0);
        @(negedge clk) rst = 1'b0;

        // round-robin among clients 0, 1, 3, then client 0 again
        clear_logs();
        bus.resp_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.resp_req  = 4'b1011;
        wait_idle("rr first", 400);
        bus.resp_req[0] = 1'b1;
        wait_idle("rr again", 200);
        exp_b = '{8'h10, 8'h11, 8'h13, 8'h10};
        exp_a = '{0, 1, 3, 0};
        check_bytes("rr", exp_b);
        check_acks("rr", exp_a);

        // dispatch table: latency, routing, ack timing, timeout and ack-on-last-cycle
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            for (int i = 0; i < 4; i++) ack_dly[i] = vecs[v].ack_dly;
            bus.cmd     = vecs[v].cmd;
            bus.cmd_rdy = 1'b1;
            start       = cyc;
            wait_idle($sformatf("vec%0d", v), 3000);
            check($sformatf("vec%0d clr latency", v), clr_cyc - start, 1);
            check($sformatf("vec%0d vld latency", v), rise_cyc - start, 2);
            check($sformatf("vec%0d dispatch count", v), disp_q.size(), 1);
            if (disp_q.size() > 0)
                check($sformatf("vec%0d vld/data", v), disp_q[0], {vecs[v].exp_vld, vecs[v].cmd});
            check($sformatf("vec%0d vld length", v), vld_len, vecs[v].exp_len);
            check($sformatf("vec%0d error bytes", v), sent_q.size(), vecs[v].exp_ee);
            if (sent_q.size() > 0) check($sformatf("vec%0d error byte", v), sent_q[0], EE);
            check($sformatf("vec%0d resp_ack count", v), ack_q.size(), 0);
        end

        // error priority: two timeouts while the channel is held, client 3 waiting too
        clear_logs();
        for (int i = 0; i < 4; i++) ack_dly[i] = 0;
        ack_dly[1]    = -1;
        hold_sent     = 1'b1;
        bus.resp_data = {8'h33, 8'h22, 8'h21, 8'h20};
        bus.resp_req  = 4'b0010;
        bus.cmd       = 16'h4001;
        bus.cmd_rdy   = 1'b1;
        wait_fall("prio tmo1", 1200);
        vld_len     = -1;
        bus.cmd     = 16'h4002;
        bus.cmd_rdy = 1'b1;
        wait_fall("prio tmo2", 1200);
        check("prio tmo2 length", vld_len, 1024);
        bus.resp_req[3] = 1'b1;
        tick();
        hold_sent = 1'b0;
        wait_idle("prio", 400);
        exp_b = '{8'h21, 8'h33, EE};
        exp_a = '{1, 3};
        check_bytes("prio", exp_b);
        check_acks("prio", exp_a);

        // cmd_rdy raised during C_DISP is consumed right after the ack
        clear_logs();
        for (int i = 0; i < 4; i++) ack_dly[i] = 10;
        bus.cmd     = 16'h0AAA;
        bus.cmd_rdy = 1'b1;
        repeat (4) tick();
        bus.cmd     = 16'h4BBB;
        bus.cmd_rdy = 1'b1;
        clr_cyc     = -1;
        wait_idle("held rdy", 200);
        check("held rdy consume after ack", clr_cyc - first_fall, 1);
        check("held rdy dispatch count", disp_q.size(), 2);
        if (disp_q.size() == 2) begin
            check("held rdy first", disp_q[0], {4'b0001, 16'h0AAA});
            check("held rdy second", disp_q[1], {4'b0010, 16'h4BBB});
        end

        // asynchronous reset in the middle of R_WAIT and C_DISP
        clear_logs();
        ack_dly[0]    = -1;
        hold_sent     = 1'b1;
        bus.resp_req  = 4'b0100;
        bus.cmd       = 16'h0123;
        bus.cmd_rdy   = 1'b1;
        repeat (6) tick();
        check("pre-reset cmd_vld", bus.cmd_vld, 4'b0001);
        check("pre-reset sent", sent_q.size(), 1);
        #2 rst = 1'b1;
        #1;
        check("async rst clr_cmd_rdy", bus.clr_cmd_rdy, 0);
        check("async rst send_resp", bus.send_resp, 0);
        check("async rst resp", bus.resp, 0);
        check("async rst cmd_vld", bus.cmd_vld, 0);
        check("async rst cmd_data", bus.cmd_data, 0);
        check("async rst resp_ack", bus.resp_ack, 0);
        check("async rst busy", bus.busy, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.resp_req = '0;
        bus.cmd_rdy  = 1'b0;
        hold_sent    = 1'b0;
        timer        = 0;
        prev_vld     = '0;
        for (int i = 0; i < 4; i++) ack_dly[i] = 0;
        clear_logs();
        repeat (30) tick();
        check("post-reset resp_ack", ack_q.size(), 0);
        check("post-reset sent", sent_q.size(), 0);
        check("post-reset busy", bus.busy, 0);

        // random commands and responses against a round-robin scoreboard
        rr_m = 0;
        for (int it = 0; it < 25; it++) begin
            clear_logs();
            c  = 16'($urandom);
            ad = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 12));
            for (int i = 0; i < 4; i++) ack_dly[i] = ad;
            m     = 4'($urandom);
            rdata = $urandom;
            oh    = 4'b0001 << c[15:14];
            exp_b.delete();
            exp_a.delete();
            last = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (rr_m + k) % 4;
                if (m[idx]) begin
                    exp_b.push_back(rdata[idx*8 +: 8]);
                    exp_a.push_back(idx);
                    last = idx;
                end
            end
            if (last >= 0) rr_m = (last + 1) % 4;
            if (ad < 0) exp_b.push_back(EE);

            bus.resp_data = rdata;
            bus.resp_req  = m;
            bus.cmd       = c;
            bus.cmd_rdy   = 1'b1;
            wait_idle($sformatf("rand%0d", it), 3000);
            check($sformatf("rand%0d dispatch count", it), disp_q.size(), 1);
            if (disp_q.size() > 0) check($sformatf("rand%0d dispatch", it), disp_q[0], {oh, c});
            check_bytes($sformatf("rand%0d", it), exp_b);
            check_acks($sformatf("rand%0d", it), exp_a);
        end

        check("resp_ack one-hot", multi_ack, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
